// File: rtl/sync_down_timer_if.sv
// Handshake/bus bundle for sync_down_timer.
//   master : drives start/abort/en/auto_reload/load_val, observes q/tc/busy/done
//   slave  : the timer itself
interface sync_down_timer_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             start;
  logic             abort;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, en, auto_reload, load_val,
    input  q, tc, busy, done
  );

  modport slave (
    input  start, abort, en, auto_reload, load_val,
    output q, tc, busy, done
  );
endinterface

// File: rtl/sync_down_timer.sv
// Loadable synchronous down-counter / timer with one-shot and auto-reload modes.
// Ports:
//   clk    : single rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : slave side of sync_down_timer_if
//            start/abort/en/auto_reload/load_val in; q/tc/busy/done out (all registered)
// Edge priority: reset > abort > start > count.
module sync_down_timer #(
  parameter int unsigned WIDTH = 4
) (
  input logic              clk,
  input logic              reset,
  sync_down_timer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (bus.abort) begin
      state_d = StIdle;
      q_d     = '0;
    end else if (bus.start) begin
      q_d      = bus.load_val;
      reload_d = bus.load_val;
      if (bus.load_val == '0) begin
        // Zero load expires immediately, regardless of auto_reload.
        tc_d    = 1'b1;
        state_d = StDone;
      end else begin
        state_d = StRun;
      end
    end else if (state_q == StRun && bus.en) begin
      // q is never 0 while running, so q<=1 is the expiry cycle.
      if (q_q > WIDTH'(1)) begin
        q_d = q_q - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
        if (bus.auto_reload) begin
          q_d = reload_q;
        end else begin
          q_d     = '0;
          state_d = StDone;
        end
      end
    end
  end

  // Output decode
  always_comb begin
    bus.q    = q_q;
    bus.tc   = tc_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state_q)
      StRun:   bus.busy = 1'b1;
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sync_down_timer.sv
module tb_sync_down_timer;

  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  sync_down_timer_if #(.WIDTH(WIDTH)) bus ();

  sync_down_timer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit start;
    bit abort;
    bit en;
    bit ar;
    int ld;
    int q;
    bit tc;
    bit busy;
    bit done;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  int m_q;
  int m_reload;
  bit m_tc;
  bit m_running;
  bit m_expired;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int q, input bit tc, input bit busy,
                           input bit done);
    check({tag, " q"}, int'(bus.q), q);
    check({tag, " tc"}, int'(bus.tc), int'(tc));
    check({tag, " busy"}, int'(bus.busy), int'(busy));
    check({tag, " done"}, int'(bus.done), int'(done));
  endtask

  task automatic drive(input bit s, input bit a, input bit e, input bit ar, input int ld);
    bus.start       = s;
    bus.abort       = a;
    bus.en          = e;
    bus.auto_reload = ar;
    bus.load_val    = WIDTH'(ld);
  endtask

  // One clock edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input bit s, input bit a, input bit e, input bit ar, input int ld,
                              input int q, input bit tc, input bit busy, input bit done);
    vec_t v;
    v.start = s; v.abort = a; v.en = e; v.ar = ar; v.ld = ld;
    v.q = q; v.tc = tc; v.busy = busy; v.done = done;
    vecs.push_back(v);
  endfunction

  function automatic void model_reset();
    m_q = 0; m_reload = 0; m_tc = 0; m_running = 0; m_expired = 0;
  endfunction

  // Behaviour of one clock edge, straight from the rules.
  function automatic void model_edge(input bit s, input bit a, input bit e, input bit ar,
                                     input int ld);
    m_tc = 0;
    if (a) begin
      m_running = 0; m_expired = 0; m_q = 0;
    end else if (s) begin
      m_q = ld; m_reload = ld;
      m_running = (ld != 0);
      m_expired = (ld == 0);
      m_tc = (ld == 0);
    end else if (m_running && e) begin
      if (m_q == 1) begin
        m_tc = 1;
        if (ar) m_q = m_reload;
        else begin
          m_q = 0; m_running = 0; m_expired = 1;
        end
      end else begin
        m_q = m_q - 1;
      end
    end
  endfunction

  initial begin
    int a;
    drive(0, 0, 0, 0, 0);

    // ---------------- Vector table ----------------
    // One-shot load 5
    add(1, 0, 0, 0, 5, 5, 0, 1, 0);
    add(0, 0, 1, 0, 0, 4, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3, 0, 1, 0);
    add(0, 0, 1, 0, 0, 2, 0, 1, 0);
    add(0, 0, 1, 0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1);
    // Auto-reload load 3, 9 enabled edges
    add(1, 0, 1, 1, 3, 3, 0, 1, 0);
    for (int r = 0; r < 3; r++) begin
      add(0, 0, 1, 1, 0, 2, 0, 1, 0);
      add(0, 0, 1, 1, 0, 1, 0, 1, 0);
      add(0, 0, 1, 1, 0, 3, 1, 1, 0);
    end
    add(0, 0, 0, 0, 0, 3, 0, 1, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Enable gating, load 4
    add(1, 0, 0, 0, 4, 4, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3, 0, 1, 0);
    add(0, 0, 0, 0, 0, 3, 0, 1, 0);
    add(0, 0, 0, 0, 0, 3, 0, 1, 0);
    add(0, 0, 1, 0, 0, 2, 0, 1, 0);
    add(0, 0, 1, 0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 1);
    // Zero load with auto_reload
    add(1, 0, 1, 1, 0, 0, 1, 0, 1);
    add(0, 0, 1, 1, 0, 0, 0, 0, 1);
    // Collisions
    add(1, 0, 0, 0, 9, 9, 0, 1, 0);
    add(1, 1, 1, 0, 7, 0, 0, 0, 0);
    add(1, 0, 1, 0, 5, 5, 0, 1, 0);
    add(0, 0, 1, 0, 0, 4, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3, 0, 1, 0);
    add(0, 0, 1, 0, 0, 2, 0, 1, 0);
    add(1, 0, 1, 0, 7, 7, 0, 1, 0);
    add(0, 0, 1, 0, 0, 6, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    #1;
    check_all("reset", 0, 0, 0, 0);
    step();
    reset = 1'b0;
    step();
    check_all("post-reset", 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].abort, vecs[i].en, vecs[i].ar, vecs[i].ld);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].tc, vecs[i].busy, vecs[i].done);
    end

    // ---------------- Max load counts down without wrap ----------------
    drive(1, 0, 1, 0, 15);
    step();
    check_all("max load", 15, 0, 1, 0);
    drive(0, 0, 1, 0, 0);
    a = 0;
    for (int k = 14; k >= 0; k--) begin
      step();
      check($sformatf("max q%0d", k), int'(bus.q), k);
      if (bus.tc) a++;
    end
    check("max tc count", a, 1);
    check("max done", int'(bus.done), 1);
    step();
    check("max no wrap", int'(bus.q), 0);

    // ---------------- Async reset mid-run ----------------
    drive(1, 0, 1, 0, 9);
    step();
    drive(0, 0, 1, 0, 0);
    step(); step(); step();
    check("midrun q6", int'(bus.q), 6);
    #2;
    reset = 1'b1;
    #1;
    check_all("async reset", 0, 0, 0, 0);
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    step();
    check_all("after reset", 0, 0, 0, 0);

    // ---------------- Randomized vs. model ----------------
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit s, ab, e, ar, rs;
      int ld;
      s  = ($urandom_range(0, 11) == 0);
      ab = ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 3) != 0);
      ar = $urandom_range(0, 1);
      ld = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 15));
      rs = ($urandom_range(0, 199) == 0);
      drive(s, ab, e, ar, ld);
      reset = rs;
      step();
      if (rs) model_reset();
      else model_edge(s, ab, e, ar, ld);
      check_all($sformatf("rnd%0d", c), m_q, m_tc, m_running, m_expired);
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
